load_return_unit: RTL



---
 rtl/load_return_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/load_return_unit.sv
// load_return_unit: registered load-data return path for hits and line refills.
// Returns the formatted load word over a valid/ready handshake and assembles refill lines.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   load request handshake (one request in flight)
//   req_mode          000 lw, 001 lh, 010 lb, 011 lbu, 100 lhu, 101 lwu, 110 ld
//   req_offset        byte offset within the cache line
//   req_miss          1 = data comes from the refill beats
//   hit_data          bank word holding the addressed byte (hit case)
//   mem_beat_valid    refill beat strobe, beats in order, no backpressure
//   mem_beat_data     refill beat payload
//   rsp_valid/ready   result handshake
//   rsp_data          sign/zero-extended load result
//   rsp_err           misaligned access or illegal mode
//   fill_valid        one-cycle pulse when fill_line is complete
//   fill_line         assembled refill line, beat k at [k*BEAT_W +: BEAT_W]
module load_return_unit #(
    parameter int XLEN       = 32,
    parameter int LINE_BYTES = 64,
    parameter int BEAT_W     = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_mode,
    input  logic [$clog2(LINE_BYTES)-1:0] req_offset,
    input  logic                          req_miss,
    input  logic [XLEN-1:0]               hit_data,
    input  logic                          mem_beat_valid,
    input  logic [BEAT_W-1:0]             mem_beat_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [XLEN-1:0]               rsp_data,
    output logic                          rsp_err,
    output logic                          fill_valid,
    output logic [LINE_BYTES*8-1:0]       fill_line
);

    localparam int OFFS_W  = $clog2(LINE_BYTES);
    localparam int NBEATS  = LINE_BYTES * 8 / BEAT_W;
    localparam int CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BEAT_SH = $clog2(BEAT_W / 8);
    localparam int WORD_SH = $clog2(XLEN / 8);
    localparam int LINE_W  = LINE_BYTES * 8;

    typedef enum logic {
        IDLE,
        FILL
    } stateE;

    stateE              state;
    logic [CNT_W-1:0]   beatCnt;
    logic [2:0]         modeReg;
    logic [OFFS_W-1:0]  offsReg;
    logic               rspValidQ;
    logic [XLEN-1:0]    rspDataQ;
    logic               rspErrQ;
    logic               fillValidQ;
    logic [LINE_W-1:0]  fillLineQ;

    logic               reqFire;
    logic               reqErr;
    logic [XLEN-1:0]    hitResult;
    logic [OFFS_W-1:0]  critBeat;
    logic [OFFS_W-1:0]  critWordIdx;
    logic               isCrit;
    logic               isLast;
    logic [XLEN-1:0]    beatWord;
    logic [XLEN-1:0]    fillResult;

    // Alignment and mode legality; lwu/ld only exist on a 64-bit datapath.
    function automatic logic modeErr(
        input logic [2:0]        mode,
        input logic [OFFS_W-1:0] offs
    );
        logic [2:0] o;
        logic       e;
        o = 3'(offs);
        case (mode)
            3'b000:         e = (o[1:0] != 2'b00);
            3'b001, 3'b100: e = o[0];
            3'b010, 3'b011: e = 1'b0;
            3'b101:         e = (XLEN == 32) || (o[1:0] != 2'b00);
            3'b110:         e = (XLEN == 32) || (o != 3'b000);
            default:        e = 1'b1;
        endcase
        return e;
    endfunction

    // Picks the byte/half/word lane inside an XLEN word and extends it.
    function automatic logic [XLEN-1:0] formatLoad(
        input logic [XLEN-1:0]   word,
        input logic [2:0]        mode,
        input logic [OFFS_W-1:0] offs
    );
        logic [OFFS_W-1:0] lane;
        logic [XLEN-1:0]   sh;
        logic [XLEN-1:0]   r;
        lane = offs & OFFS_W'(XLEN / 8 - 1);
        sh   = word >> {lane, 3'b000};
        case (mode)
            3'b000:  r = XLEN'($signed(sh[31:0]));
            3'b001:  r = XLEN'($signed(sh[15:0]));
            3'b010:  r = XLEN'($signed(sh[7:0]));
            3'b011:  r = XLEN'(sh[7:0]);
            3'b100:  r = XLEN'(sh[15:0]);
            3'b101:  r = XLEN'(sh[31:0]);
            3'b110:  r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

    // A new request may enter only when the result slot frees up this cycle.
    assign req_ready = !rst && (state == IDLE) && (!rspValidQ || rsp_ready);
    assign reqFire   = req_valid && req_ready;
    assign reqErr    = modeErr(req_mode, req_offset);
    assign hitResult = formatLoad(hit_data, req_mode, req_offset);

    // Critical beat and the XLEN word inside it for the early restart.
    assign critBeat    = offsReg >> BEAT_SH;
    assign critWordIdx = (offsReg & OFFS_W'(BEAT_W / 8 - 1)) >> WORD_SH;
    assign isCrit      = (OFFS_W'(beatCnt) == critBeat);
    assign isLast      = (beatCnt == CNT_W'(NBEATS - 1));
    assign beatWord    = XLEN'(mem_beat_data >> (int'(critWordIdx) * XLEN));
    assign fillResult  = formatLoad(beatWord, modeReg, offsReg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beatCnt    <= '0;
            modeReg    <= '0;
            offsReg    <= '0;
            rspValidQ  <= 1'b0;
            rspDataQ   <= '0;
            rspErrQ    <= 1'b0;
            fillValidQ <= 1'b0;
            fillLineQ  <= '0;
        end else begin
            fillValidQ <= 1'b0;

            // Consumed result clears; a load below overrides this.
            if (rspValidQ && rsp_ready) begin
                rspValidQ <= 1'b0;
                rspDataQ  <= '0;
                rspErrQ   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (reqFire) begin
                        if (reqErr) begin
                            rspValidQ <= 1'b1;
                            rspDataQ  <= '0;
                            rspErrQ   <= 1'b1;
                        end else if (!req_miss) begin
                            rspValidQ <= 1'b1;
                            rspDataQ  <= hitResult;
                            rspErrQ   <= 1'b0;
                        end else begin
                            state   <= FILL;
                            beatCnt <= '0;
                            modeReg <= req_mode;
                            offsReg <= req_offset;
                        end
                    end
                end
                FILL: begin
                    if (mem_beat_valid) begin
                        fillLineQ[beatCnt*BEAT_W +: BEAT_W] <= mem_beat_data;
                        beatCnt <= beatCnt + 1'b1;
                        // The request was accepted with an empty result
                        // slot, so the early word can always load here.
                        if (isCrit) begin
                            rspValidQ <= 1'b1;
                            rspDataQ  <= fillResult;
                            rspErrQ   <= 1'b0;
                        end
                        if (isLast) begin
                            fillValidQ <= 1'b1;
                            state      <= IDLE;
                            beatCnt    <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rspValidQ;
    assign rsp_data   = rspDataQ;
    assign rsp_err    = rspErrQ;
    assign fill_valid = fillValidQ;
    assign fill_line  = fillLineQ;

endmodule
